// File: rtl/vmult_arbiter.sv
// ----------------------------------------------------------------------------
// vmult_arbiter
//   Two requesters share a single 4x4 unsigned multiplier. A round-robin
//   arbiter accepts one operand pair at a time in IDLE. The operands are held
//   on the multiplier for MUL_CYCLES cycles, and then the product is registered
//   and presented on a valid/ready response port.
//
// Ports
//   clk                     sole clock, rising edge
//   rst_n                   asynchronous active-low reset
//   req0_valid/req1_valid   requester operand valid
//   req0_a/b, req1_a/b      4-bit unsigned operands
//   req0_ready/req1_ready   operand accepted this cycle (with matching valid)
//   rsp_valid               product available
//   rsp_p                   8-bit product a*b
//   rsp_id                  requester (0/1) owning rsp_p
//   rsp_ready               consumer accepts response
//   busy                    high whenever the FSM is not in IDLE
//   op_count                number of completed responses (wraps)
//
// Also contains vmulti_4bit, the shared 4x4 multiplier (shift-and-add).
// ----------------------------------------------------------------------------

// 4x4 unsigned multiplier built from four shifted partial products.
// co is the carry out of the 9-bit sum. It can never be set for 4-bit
// operands, but it is kept so the cell stays a drop-in replacement.
module vmulti_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p,
    output logic       co
);
    logic [7:0] pp [4];
    logic [8:0] sum;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pp
            assign pp[gi] = b[gi] ? ({4'b0000, a} << gi) : 8'h00;
        end
    endgenerate

    assign sum = {1'b0, pp[0]} + {1'b0, pp[1]} + {1'b0, pp[2]} + {1'b0, pp[3]};
    assign p   = sum[7:0];
    assign co  = sum[8];
endmodule

module vmult_arbiter #(
    parameter int MUL_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    output logic       req1_ready,
    output logic       rsp_valid,
    output logic [7:0] rsp_p,
    output logic       rsp_id,
    input  logic       rsp_ready,
    output logic       busy,
    output logic [7:0] op_count
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(MUL_CYCLES);

    state_t     state_q;
    logic [3:0] cnt_q;
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic       id_q;
    logic       last_q;       // requester served by the most recent accept
    logic       rsp_valid_q;
    logic [7:0] rsp_p_q;
    logic       rsp_id_q;
    logic [7:0] op_count_q;

    logic       idle;
    logic       grant;
    logic       accept;
    logic [7:0] mul_p;
    logic       mul_co_unused;

    // Under contention, the requester that was not served last wins.
    // Otherwise, grant goes to whichever requester is valid.
    assign idle       = (state_q == IDLE);
    assign grant      = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    assign req0_ready = idle && req0_valid && !grant;
    assign req1_ready = idle && req1_valid && grant;
    assign accept     = req0_ready || req1_ready;

    // The multiplier sees only the operand registers, so requester inputs
    // changing after acceptance cannot disturb the product in flight.
    vmulti_4bit u_mul (
        .a  (a_q),
        .b  (b_q),
        .p  (mul_p),
        .co (mul_co_unused)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            a_q         <= 4'd0;
            b_q         <= 4'd0;
            id_q        <= 1'b0;
            last_q      <= 1'b1;   // requester 0 wins the first contention
            rsp_valid_q <= 1'b0;
            rsp_p_q     <= 8'h00;
            rsp_id_q    <= 1'b0;
            op_count_q  <= 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q     <= grant ? req1_a : req0_a;
                        b_q     <= grant ? req1_b : req0_b;
                        id_q    <= grant;
                        last_q  <= grant;
                        cnt_q   <= CNT_LOAD;
                        state_q <= MUL;
                    end
                end
                MUL: begin
                    cnt_q <= cnt_q - 4'd1;
                    // The count reaches zero on this edge, so the product is
                    // captured here. The <= also catches a zero load, so the
                    // FSM cannot wrap the counter and stall.
                    if (cnt_q <= 4'd1) begin
                        rsp_p_q     <= mul_p;
                        rsp_id_q    <= id_q;
                        rsp_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        op_count_q  <= op_count_q + 8'd1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_p     = rsp_p_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = !idle;
    assign op_count  = op_count_q;
endmodule

// File: tb/tb_vmult_arbiter.sv
module tb_vmult_arbiter;
    typedef struct packed {
        logic       id;
        logic [7:0] p;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       req0_valid, req1_valid;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic       req0_ready, req1_ready;
    logic       rsp_valid, rsp_id, rsp_ready, busy;
    logic [7:0] rsp_p, op_count;

    // Second instance built with MUL_CYCLES=4.
    logic       d4_req0_valid, d4_req1_valid;
    logic [3:0] d4_req0_a, d4_req0_b, d4_req1_a, d4_req1_b;
    logic       d4_req0_ready, d4_req1_ready;
    logic       d4_rsp_valid, d4_rsp_id, d4_rsp_ready, d4_busy;
    logic [7:0] d4_rsp_p, d4_op_count;

    int   checks = 0;
    int   errors = 0;
    logic [7:0] exp_cnt = 8'h00;
    exp_t sb_q[$];
    exp_t sb4_q[$];

    vmult_arbiter #(.MUL_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_p(rsp_p), .rsp_id(rsp_id), .rsp_ready(rsp_ready),
        .busy(busy), .op_count(op_count)
    );

    vmult_arbiter #(.MUL_CYCLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(d4_req0_valid), .req0_a(d4_req0_a), .req0_b(d4_req0_b), .req0_ready(d4_req0_ready),
        .req1_valid(d4_req1_valid), .req1_a(d4_req1_a), .req1_b(d4_req1_b), .req1_ready(d4_req1_ready),
        .rsp_valid(d4_rsp_valid), .rsp_p(d4_rsp_p), .rsp_id(d4_rsp_id), .rsp_ready(d4_rsp_ready),
        .busy(d4_busy), .op_count(d4_op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor for the MUL_CYCLES=1 instance. It checks each new
    // response against the queue and confirms that a held response stays stable.
    initial begin : mon1
        exp_t cur;
        bit   seen;
        seen = 1'b0;
        cur  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n || !rsp_valid) begin
                seen = 1'b0;
            end else if (!seen) begin
                seen = 1'b1;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got p=0x%02h id=%0d expected no response", rsp_p, rsp_id);
                    cur.p  = rsp_p;
                    cur.id = rsp_id;
                end else begin
                    cur = sb_q.pop_front();
                    chk("rsp_p", 32'(rsp_p), 32'(cur.p));
                    chk("rsp_id", 32'(rsp_id), 32'(cur.id));
                    $display("rsp: id=%0d p=0x%02h (expected id=%0d p=0x%02h)", rsp_id, rsp_p, cur.id, cur.p);
                end
            end else begin
                chk("rsp_p_stable", 32'(rsp_p), 32'(cur.p));
                chk("rsp_id_stable", 32'(rsp_id), 32'(cur.id));
            end
        end
    end

    initial begin : mon4
        exp_t cur;
        bit   seen;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n || !d4_rsp_valid) begin
                seen = 1'b0;
            end else if (!seen) begin
                seen = 1'b1;
                if (sb4_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL d4_unexpected_rsp: got p=0x%02h expected no response", d4_rsp_p);
                end else begin
                    cur = sb4_q.pop_front();
                    chk("d4_rsp_p", 32'(d4_rsp_p), 32'(cur.p));
                    chk("d4_rsp_id", 32'(d4_rsp_id), 32'(cur.id));
                    $display("d4 rsp: id=%0d p=0x%02h (expected id=%0d p=0x%02h)", d4_rsp_id, d4_rsp_p, cur.id, cur.p);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic set_req(input bit id, input bit v, input logic [3:0] a, input logic [3:0] b);
        if (id) begin
            req1_valid = v; req1_a = a; req1_b = b;
        end else begin
            req0_valid = v; req0_a = a; req0_b = b;
        end
    endtask

    task automatic push_exp(input bit id, input logic [7:0] p);
        exp_t e;
        e.id = id;
        e.p  = p;
        sb_q.push_back(e);
    endtask

    // Waits (bounded) for a ready and reports which requester was granted.
    // The accept edge is the next posedge.
    task automatic wait_accept(output bit gid, output bit ok);
        ok  = 1'b0;
        gid = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                ok  = 1'b1;
                gid = req1_ready;
                chk("one_ready", 32'(req0_ready & req1_ready), 32'd0);
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no ready expected a grant");
        end
    endtask

    // Called just after the accept edge. Counts edges until rsp_valid is seen
    // and checks that no ready appears while busy.
    task automatic wait_rsp(input int lat);
        int n;
        bit got;
        n   = 0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            chk("busy", 32'(busy), 32'd1);
            chk("no_ready_busy", 32'(req0_ready | req1_ready), 32'd0);
            if (rsp_valid) got = 1'b1;
            else begin
                @(posedge clk);
                n++;
            end
        end
        chk("rsp_seen", 32'(got), 32'd1);
        chk("latency", 32'(n), 32'(lat));
    endtask

    task automatic complete();
        @(posedge clk); #1;
        exp_cnt = exp_cnt + 8'd1;
        chk("op_count", 32'(op_count), 32'(exp_cnt));
        chk("busy_clear", 32'(busy), 32'd0);
    endtask

    // One request from a single requester, with hand-computed product p.
    task automatic txn(input bit id, input logic [3:0] a, input logic [3:0] b, input logic [7:0] p);
        bit gid, ok;
        set_req(id, 1'b0, ~a, ~b);        // operands changing while invalid have no effect
        @(posedge clk); #1;
        set_req(id, 1'b1, a, b);
        wait_accept(gid, ok);
        if (ok) begin
            chk("grant", 32'(gid), 32'(id));
            push_exp(id, p);
        end
        @(posedge clk); #1;
        set_req(id, 1'b0, a ^ 4'h5, b ^ 4'h3);  // post-accept changes must not matter
        if (ok) begin
            wait_rsp(1);
            complete();
        end
    endtask

    // Both requesters held valid for n transfers; grants must alternate from `first`.
    task automatic both(input int n, input bit first,
                        input logic [3:0] a0, input logic [3:0] b0, input logic [7:0] p0,
                        input logic [3:0] a1, input logic [3:0] b1, input logic [7:0] p1);
        bit gid, ok;
        set_req(1'b0, 1'b1, a0, b0);
        set_req(1'b1, 1'b1, a1, b1);
        for (int k = 0; k < n; k++) begin
            wait_accept(gid, ok);
            if (!ok) break;
            chk("rr_grant", 32'(gid), 32'(first ^ k[0]));
            push_exp(gid, gid ? p1 : p0);
            @(posedge clk); #1;
            if (k == n - 1) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            wait_rsp(1);
            complete();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n   = 1'b1;
        exp_cnt = 8'h00;
    endtask

    initial begin : stim
        bit gid, ok, got;
        int n;
        rst_n = 1'b0;
        req0_valid = 0; req0_a = 0; req0_b = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0;
        rsp_ready = 1'b1;
        d4_req0_valid = 0; d4_req0_a = 0; d4_req0_b = 0;
        d4_req1_valid = 0; d4_req1_a = 0; d4_req1_b = 0;
        d4_rsp_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_p", 32'(rsp_p), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_d4_busy", 32'(d4_busy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // req0 only, 0*1
        txn(1'b0, 4'h0, 4'h1, 8'h00);

        // MUL_CYCLES=4 instance: 7*9 = 0x3F, exactly 4 edges after accept
        d4_req0_valid = 1'b1; d4_req0_a = 4'h7; d4_req0_b = 4'h9;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (d4_req0_ready) ok = 1'b1;
        end
        chk("d4_accept", 32'(ok), 32'd1);
        begin
            exp_t e;
            e.id = 1'b0;
            e.p  = 8'h3F;
            sb4_q.push_back(e);
        end
        @(posedge clk); #1;
        d4_req0_valid = 1'b0; d4_req0_a = 4'h0; d4_req0_b = 4'h0;
        n = 0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (d4_rsp_valid) got = 1'b1;
            else begin
                @(posedge clk);
                n++;
            end
        end
        chk("d4_rsp_seen", 32'(got), 32'd1);
        chk("d4_latency", 32'(n), 32'd4);
        @(posedge clk); #1;
        chk("d4_op_count", 32'(d4_op_count), 32'd1);

        // Contention after reset: req0 first (1*2), then req1 (10*10)
        do_reset();
        both(2, 1'b0, 4'h1, 4'h2, 8'h02, 4'hA, 4'hA, 8'h64);

        // Continuous contention: 0,1,0,1
        do_reset();
        both(4, 1'b0, 4'h3, 4'h5, 8'h0F, 4'h6, 4'h7, 8'h2A);

        // Assorted single requests
        txn(1'b1, 4'hC, 4'hD, 8'h9C);
        txn(1'b0, 4'h8, 4'h8, 8'h40);

        // Back-pressure: 15*15 held for 5 cycles with req0 waiting
        rsp_ready = 1'b0;
        set_req(1'b1, 1'b1, 4'hF, 4'hF);
        wait_accept(gid, ok);
        chk("stall_grant", 32'(gid), 32'd1);
        push_exp(1'b1, 8'hE1);
        @(posedge clk); #1;
        set_req(1'b1, 1'b0, 4'h0, 4'h0);
        set_req(1'b0, 1'b1, 4'h2, 4'h3);
        wait_rsp(1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_p", 32'(rsp_p), 32'hE1);
            chk("stall_id", 32'(rsp_id), 32'd1);
            chk("stall_busy", 32'(busy), 32'd1);
            chk("stall_no_ready", 32'(req0_ready | req1_ready), 32'd0);
        end
        set_req(1'b0, 1'b0, 4'h0, 4'h0);
        rsp_ready = 1'b1;
        complete();
        // rsp_ready high with nothing pending must not count
        repeat (3) @(posedge clk);
        #1;
        chk("idle_rsp_ready_ignored", 32'(op_count), 32'(exp_cnt));

        // Reset during MUL with 10*10 in flight: discarded
        set_req(1'b0, 1'b1, 4'hA, 4'hA);
        wait_accept(gid, ok);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 4'h0, 4'h0);
        rst_n = 1'b0;
        #1;
        chk("mrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mrst_rsp_p", 32'(rsp_p), 32'd0);
        chk("mrst_rsp_id", 32'(rsp_id), 32'd0);
        chk("mrst_op_count", 32'(op_count), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        exp_cnt = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_req(1'b1, 1'b1, 4'h5, 4'h5);
        @(negedge clk);
        chk("ready_first_cycle", 32'(req1_ready), 32'd1);
        chk("no_late_rsp", 32'(rsp_valid), 32'd0);
        push_exp(1'b1, 8'h19);
        @(posedge clk); #1;
        set_req(1'b1, 1'b0, 4'h0, 4'h0);
        wait_rsp(1);
        complete();

        // op_count wrap after 256 completions
        do_reset();
        for (int i = 0; i < 256; i++) begin
            txn(i[0], 4'(i), 4'h1, {4'h0, 4'(i)});
        end
        chk("op_count_wrap", 32'(op_count), 32'h00);

        repeat (3) @(posedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        chk("sb4_empty", 32'(sb4_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vmult_arbiter.md
VMULT_ARBITER -- requirements
Module: vmult_arbiter

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 1, number of cycles operands are held on the shared multiplier before product capture (legal 1..15).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports req0_valid/req1_valid  input  1 each  requester operand valid.
REQ-005 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  4 each  unsigned operands.
REQ-006 SHALL have ports req0_ready/req1_ready  output  1 each  operand accepted this cycle when high with matching valid.
REQ-007 SHALL have port rsp_valid  output  1  product available.
REQ-008 SHALL have port rsp_p  output  8  unsigned product a*b.
REQ-009 SHALL have port rsp_id  output  1  requester index (0/1) owning rsp_p.
REQ-010 SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port op_count  output  8  count of completed responses.

Function
REQ-013 SHALL contain exactly one instance of vmulti_4bit (ports a, b, p, co), shared by both requesters; co SHALL be left unused, product taken from p only.
REQ-014 SHALL implement FSM states IDLE, MUL, DONE.
REQ-015 IDLE: reqN_ready SHALL equal (state==IDLE) AND grant==N, computed combinationally; at most one ready high per cycle.
REQ-016 Arbitration round-robin: only one valid -> grant it; both valid -> grant the requester not served by the last accepted transfer; neither -> no ready.
REQ-017 Accept edge (valid&&ready) SHALL latch a, b and id into operand registers driving the multiplier, update last-served pointer, load cycle counter with MUL_CYCLES, go to MUL.
REQ-018 MUL: counter SHALL decrement each cycle; on the edge where it reaches zero, SHALL register p into rsp_p, set rsp_valid=1, go to DONE; rsp_valid therefore rises exactly MUL_CYCLES edges after the accept edge.
REQ-019 DONE: rsp_valid, rsp_p, rsp_id SHALL stay stable while rsp_ready low; on edge with rsp_ready high SHALL clear rsp_valid, increment op_count, return to IDLE.
REQ-020 No new request SHALL be accepted in the same cycle a response completes; minimum issue interval = MUL_CYCLES+2 cycles.
REQ-021 Requester valid dropping or operand changing while not accepted SHALL have no effect; operands after acceptance SHALL not affect the in-flight product.
REQ-022 op_count SHALL wrap 255 -> 0 without affecting other behaviour.
REQ-023 Product SHALL be exact: 15*15 = 0xE1, maximum value; no truncation.
REQ-024 rsp_ready high while rsp_valid low SHALL be ignored.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, rsp_valid=0, rsp_p=0x00, rsp_id=0, op_count=0x00, busy=0, counter=0, operand registers 0, last-served pointer=1 (requester 0 wins first contention).
REQ-026 Reset asserted in MUL or DONE SHALL discard the in-flight operation with no response; after release block SHALL be in IDLE, ready per REQ-015 on the first cycle.

Verification
REQ-027 Reset, then req0 only a=0x0 b=0x1 -> req0_ready high in IDLE, rsp_valid after 1 edge (MUL_CYCLES=1), rsp_p=0x00, rsp_id=0, op_count=1 after rsp_ready.
REQ-028 Both valid simultaneously after reset, req0 a=0x1 b=0x2, req1 a=0xA b=0xA -> req0 served first rsp_p=0x02 id=0, then req1 rsp_p=0x64 id=1.
REQ-029 Both held valid continuously for 4 transactions -> grants alternate 0,1,0,1; no ready during MUL/DONE.
REQ-030 req1 a=0xF b=0xF, rsp_ready held low 5 cycles -> rsp_valid/rsp_p=0xE1/rsp_id=1 stable all 5 cycles, busy high, both readys low.
REQ-031 rst_n pulsed low during MUL with a=0xA b=0xA in flight -> no rsp_valid, all outputs at reset values; next request completes correctly.
REQ-032 MUL_CYCLES=4 build, a=0x7 b=0x9 -> rsp_valid rises exactly 4 edges after accept, rsp_p=0x3F; 256 completions -> op_count wraps to 0x00.
